// File: rtl/ps2_scan_ctrl.sv
// PS/2 Set-2 scan-code sequencer: gates the byte receiver, folds E0/F0/E1
// prefix sequences into single key events and hands them out over valid/ack.
module ps2_scan_ctrl #(
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  input  logic       key_ack,
  output logic       err_tick
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned PW = 3;
  // Expiry is taken on the cycle the counter would step onto TIMEOUT-1.
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 2);
  localparam logic [PW-1:0] PAUSE_BYTES = PW'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXT   = 3'd1,
    BRK   = 3'd2,
    PAUSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          ext_q, ext_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          rx_en_d;
  logic          key_valid_d;
  logic [7:0]    key_code_d;
  logic          key_ext_d;
  logic          key_break_d;
  logic          err_d;

  logic          emit;
  logic [7:0]    emit_code;
  logic          emit_ext;
  logic          emit_brk;
  logic          expired;

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

  assign expired = (cnt_q == TO_LAST) && !rx_done_tick;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ext_q     <= 1'b0;
      pause_q   <= '0;
      cnt_q     <= '0;
      rx_en     <= 1'b1;
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      err_tick  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_d;
      pause_q   <= pause_d;
      cnt_q     <= cnt_d;
      rx_en     <= rx_en_d;
      key_valid <= key_valid_d;
      key_code  <= key_code_d;
      key_ext   <= key_ext_d;
      key_break <= key_break_d;
      err_tick  <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    pause_d     = pause_q;
    key_valid_d = key_valid;
    key_code_d  = key_code;
    key_ext_d   = key_ext;
    key_break_d = key_break;
    err_d       = 1'b0;
    emit        = 1'b0;
    emit_code   = rx_data;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;

    if (rx_done_tick || state_q == IDLE || state_q == HOLD) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          unique case (rx_data)
            8'hE0: begin
              state_d = EXT;
              ext_d   = 1'b1;
            end
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = PAUSE;
              pause_d = PAUSE_BYTES;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: err_d = 1'b1;
            default: emit = 1'b1;
          endcase
        end
      end

      EXT: begin
        if (rx_done_tick) begin
          if (rx_data == 8'hF0) begin
            state_d = BRK;
          end else if (rx_data == 8'hE0) begin
            state_d = EXT;
          end else if (is_overrun(rx_data)) begin
            state_d = IDLE;
            ext_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
      end

      BRK: begin
        if (rx_done_tick) begin
          if (is_overrun(rx_data) || rx_data == 8'hE0 || rx_data == 8'hF0 ||
              rx_data == 8'hE1) begin
            state_d = IDLE;
            ext_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = ext_q;
            emit_brk = 1'b1;
          end
        end
      end

      PAUSE: begin
        if (rx_done_tick) begin
          pause_d = pause_q - PW'(1);
          if (pause_q == PW'(1)) begin
            emit      = 1'b1;
            emit_code = 8'hE1;
          end
        end
      end

      HOLD: begin
        // A frame already in flight when rx_en dropped is discarded.
        if (rx_done_tick) begin
          err_d = 1'b1;
        end
        if (key_ack) begin
          state_d     = IDLE;
          key_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        ext_d   = 1'b0;
      end
    endcase

    if ((state_q == EXT || state_q == BRK || state_q == PAUSE) && expired) begin
      state_d = IDLE;
      ext_d   = 1'b0;
      pause_d = '0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end

    if (emit) begin
      state_d     = HOLD;
      ext_d       = 1'b0;
      pause_d     = '0;
      key_valid_d = 1'b1;
      key_code_d  = emit_code;
      key_ext_d   = emit_ext;
      key_break_d = emit_brk;
    end

    rx_en_d = (state_d != HOLD);
  end

endmodule
